// File: rtl/truth_table_sweeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : truth_table_sweeper
// Description : Walks every input vector of a set of 3-input expression blocks,
//               holds each vector for a settle period, samples the block
//               outputs into per-function truth tables and flags any function
//               whose table differs from a golden table.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_FUNC = 3,
    parameter int SETTLE = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [N_FUNC*(2**N_IN)-1:0]     expected,
    input  logic [N_FUNC-1:0]               f_in,
    output logic [N_IN-1:0]                 abc,
    output logic                            busy,
    output logic                            done,
    output logic [N_FUNC*(2**N_IN)-1:0]     captured_table,
    output logic [N_FUNC-1:0]               mismatch
);

    localparam int              c_VEC      = 2**N_IN;
    localparam int              c_TW       = N_FUNC*c_VEC;
    localparam logic [3:0]      c_CNT_LOAD = 4'(SETTLE-1);
    localparam logic [N_IN-1:0] c_IDX_LAST = N_IN'(c_VEC-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N_IN-1:0]   r_idx, w_idx_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [N_IN-1:0]   r_abc, w_abc_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [c_TW-1:0]   r_table, w_table_nxt;
    logic [N_FUNC-1:0] r_mismatch, w_mismatch_nxt;
    logic [N_FUNC-1:0] w_slice_diff;

    // Per-function comparison of the captured table against the golden table.
    genvar gf;
    generate
        for (gf = 0; gf < N_FUNC; gf++) begin : g_slice_diff
            assign w_slice_diff[gf] = |(r_table[gf*c_VEC +: c_VEC] ^ expected[gf*c_VEC +: c_VEC]);
        end
    endgenerate

    // State register and registered outputs; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_abc      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_table    <= '0;
            r_mismatch <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_abc      <= w_abc_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_table    <= w_table_nxt;
            r_mismatch <= w_mismatch_nxt;
        end
    end

    // Next-state and next-output logic; outputs are precomputed so that the
    // registered abc/busy line up with the state they describe.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_abc_nxt      = r_abc;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_table_nxt    = r_table;
        w_mismatch_nxt = r_mismatch;
        case (r_state)
            S_IDLE: begin
                w_abc_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_table_nxt    = '0;
                    w_mismatch_nxt = '0;
                    w_idx_nxt      = '0;
                    w_cnt_nxt      = c_CNT_LOAD;
                    w_abc_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                // Decoded write keeps every table index a constant.
                for (int f = 0; f < N_FUNC; f++) begin
                    for (int v = 0; v < c_VEC; v++) begin
                        if (r_idx == N_IN'(v)) begin
                            w_table_nxt[f*c_VEC + v] = f_in[f];
                        end
                    end
                end
                if (r_idx == c_IDX_LAST) begin
                    w_abc_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_abc_nxt   = r_idx + 1'b1;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                w_mismatch_nxt = w_slice_diff;
                w_done_nxt     = 1'b1;
                w_abc_nxt      = '0;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign abc            = r_abc;
    assign busy           = r_busy;
    assign done           = r_done;
    assign captured_table = r_table;
    assign mismatch       = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper. Two instances:
//               SETTLE=1 with ideal expression blocks, SETTLE=3 with blocks
//               whose outputs lag abc by two cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam logic [23:0] GOLD = 24'hDB7B6E;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [23:0] expected;
    logic [2:0]  f_in_a, f_in_b;
    logic [2:0]  abc_a, abc_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [23:0] table_a, table_b;
    logic [2:0]  mismatch_a, mismatch_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int done_cnt_a = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .N_FUNC(3), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected),
        .f_in(f_in_a), .abc(abc_a), .busy(busy_a), .done(done_a),
        .captured_table(table_a), .mismatch(mismatch_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_FUNC(3), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected),
        .f_in(f_in_b), .abc(abc_b), .busy(busy_b), .done(done_b),
        .captured_table(table_b), .mismatch(mismatch_b)
    );

    // Behaviour of the expression blocks, given by their truth tables.
    function automatic logic gold_bit(input int f, input int v);
        logic [23:0] t;
        t = GOLD >> (f*8 + v);
        return t[0];
    endfunction

    function automatic logic [7:0] slice8(input logic [23:0] x, input int f);
        return 8'(x >> (f*8));
    endfunction

    always_comb begin
        f_in_a = '0;
        for (int f = 0; f < 3; f++) f_in_a[f] = gold_bit(f, int'(abc_a));
    end

    logic [2:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        d1 <= abc_b;
        d2 <= d1;
    end
    always_comb begin
        f_in_b = '0;
        for (int f = 0; f < 3; f++) f_in_b[f] = gold_bit(f, int'(d2));
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    // ---------------- behavioural model ----------------
    // rel = cycles since the accepted start (-1 when idle). With P cycles per
    // vector, vector rel/P is on abc while rel < 8P; vector v is sampled on the
    // edge where rel reaches (v+1)*P; done follows one cycle after rel == 8P.
    int          rel[2]   = '{-1, -1};
    logic [23:0] m_tbl[2] = '{24'h0, 24'h0};
    logic [2:0]  m_mm[2]  = '{3'h0, 3'h0};
    logic        m_done[2] = '{1'b0, 1'b0};

    task automatic step(input int k, input int p, input logic st);
        int l;
        l = 8*p;
        if (!rst_n) begin
            rel[k] = -1; m_tbl[k] = '0; m_mm[k] = '0; m_done[k] = 1'b0;
        end else begin
            m_done[k] = (rel[k] == l);
            if (rel[k] == l) begin
                for (int f = 0; f < 3; f++)
                    m_mm[k][f] = (slice8(m_tbl[k], f) != slice8(expected, f));
                rel[k] = -1;
            end else if (rel[k] >= 0) begin
                rel[k] = rel[k] + 1;
                if (rel[k] % p == 0)
                    for (int f = 0; f < 3; f++)
                        m_tbl[k] = m_tbl[k] | (24'(gold_bit(f, rel[k]/p - 1)) << (f*8 + rel[k]/p - 1));
            end else if (st) begin
                rel[k] = 0; m_tbl[k] = '0; m_mm[k] = '0;
            end
        end
    endtask

    function automatic int exp_busy(input int k, input int p);
        return (rel[k] >= 0 && rel[k] < 8*p) ? 1 : 0;
    endfunction

    function automatic int exp_abc(input int k, input int p);
        return (exp_busy(k, p) != 0) ? rel[k]/p : 0;
    endfunction

    always @(posedge clk) begin
        step(0, 2, start_a);
        step(1, 4, start_b);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a_busy", 32'(busy_a), 32'(exp_busy(0, 2)));
            cmp("a_abc", 32'(abc_a), 32'(exp_abc(0, 2)));
            cmp("a_done", 32'(done_a), 32'(m_done[0]));
            cmp("a_table", 32'(table_a), 32'(m_tbl[0]));
            cmp("a_mismatch", 32'(mismatch_a), 32'(m_mm[0]));
            cmp("b_busy", 32'(busy_b), 32'(exp_busy(1, 4)));
            cmp("b_abc", 32'(abc_b), 32'(exp_abc(1, 4)));
            cmp("b_done", 32'(done_b), 32'(m_done[1]));
            cmp("b_table", 32'(table_b), 32'(m_tbl[1]));
            cmp("b_mismatch", 32'(mismatch_b), 32'(m_mm[1]));
        end
    end

    // Waits for a done pulse on instance k; returns the edge it followed.
    task automatic wait_done(input int k, output int edge_at);
        edge_at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((k == 0 ? done_a : done_b) === 1'b1) begin
                edge_at = cyc;
                break;
            end
        end
        if (edge_at < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: instance %0d got no done, required one within 200 cycles", k);
        end
    endtask

    task automatic sweep_a(output int lat);
        int e0, t;
        @(negedge clk);
        start_a = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, t);
        lat = t - e0;
    endtask

    int lat, e0, t, c0;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; expected = GOLD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_busy", 32'(busy_a), 32'd0);
        cmp("reset_table", 32'(table_a), 32'd0);
        cmp("reset_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;

        // Basic sweep with matching golden table.
        sweep_a(lat);
        cmp("s1_latency", 32'(lat), 32'd17);
        cmp("s1_table", 32'(table_a), 32'hDB7B6E);
        cmp("s1_mismatch", 32'(mismatch_a), 32'h0);

        // Golden tables differing in function 0, then function 2.
        expected = 24'hDB7B6F;
        sweep_a(lat);
        cmp("s2_mismatch_f0", 32'(mismatch_a), 32'h1);
        expected = 24'hDA7B6E;
        sweep_a(lat);
        cmp("s2_mismatch_f2", 32'(mismatch_a), 32'h4);
        expected = GOLD;
        repeat (2) @(negedge clk);

        // start re-pulsed during the sweep is ignored.
        c0 = done_cnt_a;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 0) e0 = cyc + 1;
            start_a = (n == 0 || n == 3 || n == 10);
        end
        start_a = 1'b0;
        wait_done(0, t);
        cmp("s3_latency", 32'(t - e0), 32'd17);
        cmp("s3_table", 32'(table_a), 32'hDB7B6E);
        repeat (20) @(negedge clk);
        cmp("s3_done_count", 32'(done_cnt_a - c0), 32'd1);

        // Reset mid-sweep at idx 4.
        c0 = done_cnt_a;
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            start_a = (n == 0);
            if (n == 9) begin
                cmp("s4_abc_before_rst", 32'(abc_a), 32'd4);
                rst_n = 1'b0;
            end
            if (n == 10) begin
                cmp("s4_busy_after_rst", 32'(busy_a), 32'd0);
                cmp("s4_abc_after_rst", 32'(abc_a), 32'd0);
                cmp("s4_table_after_rst", 32'(table_a), 32'd0);
                rst_n = 1'b1;
            end
        end
        repeat (25) @(negedge clk);
        cmp("s4_no_done", 32'(done_cnt_a - c0), 32'd0);
        sweep_a(lat);
        cmp("s4_restart_latency", 32'(lat), 32'd17);
        cmp("s4_restart_table", 32'(table_a), 32'hDB7B6E);

        // SETTLE=3 with lagging expression outputs.
        @(negedge clk);
        start_b = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1, t);
        cmp("s5_latency", 32'(t - e0), 32'd33);
        cmp("s5_table", 32'(table_b), 32'hDB7B6E);
        cmp("s5_mismatch", 32'(mismatch_b), 32'h0);

        // start held high: back-to-back sweeps.
        @(negedge clk);
        start_a = 1'b1;
        e0 = cyc + 1;
        wait_done(0, t);
        cmp("s6_done1", 32'(t - e0), 32'd17);
        cmp("s6_table1", 32'(table_a), 32'hDB7B6E);
        wait_done(0, t);
        cmp("s6_done2", 32'(t - e0), 32'd35);
        cmp("s6_table2", 32'(table_a), 32'hDB7B6E);
        wait_done(0, t);
        cmp("s6_done3", 32'(t - e0), 32'd53);
        cmp("s6_table3", 32'(table_a), 32'hDB7B6E);
        start_a = 1'b0;
        repeat (25) @(negedge clk);
        cmp("s6_idle_busy", 32'(busy_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
